// File: rtl/slot_change_tx.sv
// Transmit side of the change-counting slot link: emits NUM_SLOTS stored payloads per frame, each held HOLD_CYCLES cycles.
// Latency: first word of a frame appears on the edge that samples start; slot n follows at k + n*HOLD_CYCLES.
// Backpressure: none; start is accepted only in IDLE/FIN and ignored (not queued) while a frame is in progress.
module slot_change_tx #(
  parameter int NUM_SLOTS   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int PAYLOAD_W   = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [2:0]           wr_addr,
  input  logic [PAYLOAD_W-1:0] wr_data,
  input  logic                 start,
  output logic [PAYLOAD_W:0]   A_out,
  output logic [2:0]           sel_out,
  output logic                 word_strobe,
  output logic                 busy,
  output logic                 done
);

  // Hold counter only needs to reach HOLD_CYCLES-1; keep at least one bit.
  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]        LAST_SLOT = 3'(NUM_SLOTS - 1);
  localparam logic [3:0]        SLOT_LIM  = 4'(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                 state;
  logic                   toggle;
  logic [2:0]             slot;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [PAYLOAD_W-1:0]   mem [8];

  logic                   wr_accept;
  logic                   hold_expired;
  logic                   last_slot;
  logic [2:0]             next_slot;

  // Writes to slots beyond the frame length are dropped so they can never be emitted.
  assign wr_accept    = wr_en && ({1'b0, wr_addr} < SLOT_LIM);
  assign hold_expired = (hold_cnt == HOLD_LAST);
  assign last_slot    = (slot == LAST_SLOT);
  assign next_slot    = slot + 3'd1;

  // Payload register file; an emission on the write edge reads the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_accept) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Frame sequencer: every emission flips the toggle so the receiver sees a change per slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      toggle      <= 1'b0;
      slot        <= 3'd0;
      hold_cnt    <= '0;
      A_out       <= '0;
      sel_out     <= 3'd0;
      word_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      word_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state       <= SEND;
            slot        <= 3'd0;
            hold_cnt    <= '0;
            A_out       <= {~toggle, mem[0]};
            toggle      <= ~toggle;
            sel_out     <= 3'd0;
            word_strobe <= 1'b1;
            busy        <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (hold_expired) begin
            hold_cnt <= '0;
            if (last_slot) begin
              // Frame complete: leave the last word on the bus, no new emission.
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              slot        <= next_slot;
              A_out       <= {~toggle, mem[next_slot]};
              toggle      <= ~toggle;
              sel_out     <= next_slot;
              word_strobe <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_change_tx.sv
// Self-checking bench for slot_change_tx: three instances (8x4, 4x4, 1x1) exercised one at a time.
// Expected words are queued when start is driven and popped on the edge they are due.
// Outputs are sampled on the falling edge; inputs change on the falling edge too.
module tb_slot_change_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [22:0] wr_data = 23'd0;
  logic        start [3];

  logic [23:0] a_out [3];
  logic [2:0]  sel [3];
  logic        ws [3];
  logic        busy [3];
  logic        done [3];

  always #5 clk = ~clk;

  slot_change_tx #(.NUM_SLOTS(8), .HOLD_CYCLES(4), .PAYLOAD_W(23)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start[0]), .A_out(a_out[0]), .sel_out(sel[0]), .word_strobe(ws[0]),
    .busy(busy[0]), .done(done[0]));

  slot_change_tx #(.NUM_SLOTS(4), .HOLD_CYCLES(4), .PAYLOAD_W(23)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start[1]), .A_out(a_out[1]), .sel_out(sel[1]), .word_strobe(ws[1]),
    .busy(busy[1]), .done(done[1]));

  slot_change_tx #(.NUM_SLOTS(1), .HOLD_CYCLES(1), .PAYLOAD_W(23)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start[2]), .A_out(a_out[2]), .sel_out(sel[2]), .word_strobe(ws[2]),
    .busy(busy[2]), .done(done[2]));

  typedef struct {
    int          d;
    int          e;
    logic [23:0] a;
    logic [2:0]  sel;
  } exp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [22:0] data;
    logic [23:0] exp_a;
    logic [2:0]  exp_sel;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl [8];
  int          ns [3];
  int          hs [3];
  logic [22:0] m [3][8];
  logic        tog [3];
  logic [23:0] last_a [3];
  logic [2:0]  last_sel [3];
  int          busy_from [3];
  int          busy_to [3];
  int          done_at [3];
  int          edge_n = 0;
  int          nvec = 0;
  int          nfail = 0;
  bit          chg_on = 1'b0;
  logic [2:0]  chg = 3'd0;
  logic [23:0] prev_a = 24'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, got, exp);
    end
  endtask

  task automatic monitor();
    bit   matched [3];
    exp_t it;
    for (int d = 0; d < 3; d++) matched[d] = 1'b0;
    while (q.size() > 0 && q[0].e <= edge_n) begin
      it = q.pop_front();
      chk("word_strobe", 32'(ws[it.d]), 32'd1);
      chk("A_out", 32'(a_out[it.d]), 32'(it.a));
      chk("sel_out", 32'(sel[it.d]), 32'(it.sel));
      last_a[it.d]   = it.a;
      last_sel[it.d] = it.sel;
      matched[it.d]  = 1'b1;
    end
    for (int d = 0; d < 3; d++) begin
      if (!matched[d]) begin
        chk("no_strobe", 32'(ws[d]), 32'd0);
        chk("A_out_hold", 32'(a_out[d]), 32'(last_a[d]));
        chk("sel_hold", 32'(sel[d]), 32'(last_sel[d]));
      end
      chk("busy", 32'(busy[d]), 32'(edge_n >= busy_from[d] && edge_n < busy_to[d]));
      chk("done", 32'(done[d]), 32'(edge_n == done_at[d]));
    end
    // Independent receiver: count bus changes to rebuild the slot selector.
    if (chg_on) begin
      if (a_out[0] !== prev_a) begin
        chg = chg + 3'd1;
        chk("rx_change_sel", 32'(sel[0]), 32'(chg));
      end
      prev_a = a_out[0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    monitor();
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic push_word(input int d, input int e, input int n);
    exp_t it;
    tog[d] = ~tog[d];
    it.d   = d;
    it.e   = e;
    it.a   = {tog[d], m[d][n]};
    it.sel = 3'(n);
    q.push_back(it);
  endtask

  task automatic push_frame(input int d, input int k);
    for (int n = 0; n < ns[d]; n++) push_word(d, k + n * hs[d], n);
    busy_from[d] = k;
    busy_to[d]   = k + ns[d] * hs[d];
    done_at[d]   = k + ns[d] * hs[d];
  endtask

  task automatic start_frame(input int d, output int k);
    k = edge_n + 1;
    push_frame(d, k);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [22:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    for (int d = 0; d < 3; d++) if (int'(addr) < ns[d]) m[d][addr] = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      tog[d]      = 1'b0;
      last_a[d]   = 24'd0;
      last_sel[d] = 3'd0;
      done_at[d]  = 0;
      if (busy_to[d] > edge_n + 1) busy_to[d] = edge_n + 1;
      for (int i = 0; i < 8; i++) m[d][i] = 23'd0;
    end
    while (q.size() > 0 && q[q.size()-1].e > edge_n) void'(q.pop_back());
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    ns = '{8, 4, 1};
    hs = '{4, 4, 1};
    for (int d = 0; d < 3; d++) begin
      start[d]     = 1'b0;
      busy_from[d] = 0;
      busy_to[d]   = 0;
    end

    // Reset from time zero; all outputs must come up zero.
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_A_out", 32'(a_out[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
    end

    // Basic frame from a vector table: payload i+1 in slot i, toggle alternating from 1.
    for (int i = 0; i < 8; i++) begin
      tbl[i].addr    = 3'(i);
      tbl[i].data    = 23'(i + 1);
      tbl[i].exp_a   = {(i % 2 == 0) ? 1'b1 : 1'b0, 23'(i + 1)};
      tbl[i].exp_sel = 3'(i);
    end
    for (int i = 0; i < 8; i++) wr(tbl[i].addr, tbl[i].data);
    k = edge_n + 1;
    for (int i = 0; i < 8; i++) begin
      exp_t it;
      tog[0] = ~tog[0];
      it.d   = 0;
      it.e   = k + 4 * i;
      it.a   = tbl[i].exp_a;
      it.sel = tbl[i].exp_sel;
      q.push_back(it);
    end
    busy_from[0] = k;
    busy_to[0]   = k + 32;
    done_at[0]   = k + 32;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    run_to(k + 34);

    // start pulses while busy are ignored; exactly one done.
    start_frame(0, k);
    run_to(k + 4);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_to(k + 9);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_to(k + 34);

    // Write collides with slot-3 emission (old value), write before slot 4 (new value).
    start_frame(0, k);
    run_to(k + 11);
    wr(3'd3, 23'h123456);
    wr(3'd4, 23'h0ABCDE);
    foreach (q[i]) if (q[i].d == 0 && q[i].sel == 3'd4) q[i].a[22:0] = 23'h0ABCDE;
    run_to(k + 34);

    // Address 7 is outside the 4-slot instance and must not alias onto slot 3.
    wr(3'd7, 23'h555555);
    start_frame(1, k);
    run_to(k + 18);

    // Identical payloads, back-to-back frames with start held high.
    for (int i = 0; i < 8; i++) wr(3'(i), 23'h7FFFFF);
    chg_on = 1'b1;
    chg    = 3'b111;
    prev_a = last_a[0];
    k = edge_n + 1;
    push_frame(0, k);
    start[0] = 1'b1;
    tick();
    run_to(k + 32);
    push_frame(0, k + 33);
    tick();
    start[0] = 1'b0;
    run_to(k + 67);
    chg_on = 1'b0;

    // Reset mid-frame: outputs clear, no done, toggle restarts.
    start_frame(0, k);
    run_to(k + 9);
    do_reset();
    wr(3'd0, 23'h000055);
    start_frame(0, k);
    run_to(k + 34);

    // Single slot, single-cycle hold, restart accepted from FIN.
    wr(3'd0, 23'h00000A);
    k = edge_n + 1;
    push_frame(2, k);
    start[2] = 1'b1;
    tick();
    tick();
    push_frame(2, k + 2);
    tick();
    start[2] = 1'b0;
    run_to(k + 5);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
